tinyvga_gen: RTL and testbench
==============================

# tinyvga_gen

Source side of the TinyVGA PMOD byte. The block generates 640x480@60 raster timing from the 50 MHz design clock. It supplies pixel coordinates to a renderer, samples the renderer's 2-bit-per-channel colour, and emits the packed 8-bit VGA word on `uo_out`. The FPGA top level unpacks that word onto the board's VGA connector.

## Interface

Parameters:
- `CLK_DIV`, 2: design clocks per pixel (50 MHz / 2 = 25 MHz pixel rate)
- `H_ACTIVE`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal timing, in pixels
- `V_ACTIVE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical timing, in lines

Ports:
- `clock` in 1: single clock
- `reset` in 1: asynchronous, active-high
- `enable` in 1: 0 freezes the raster
- `pix_r` in 2: renderer colour for the current `hpos`/`vpos`, red
- `pix_g` in 2: renderer colour, green
- `pix_b` in 2: renderer colour, blue
- `hpos` out 10: current pixel column, 0..799, registered
- `vpos` out 10: current line, 0..524, registered
- `active` out 1: `hpos`<640 and `vpos`<480
- `pix_tick` out 1: one-clock strobe, asserted on the clock where the raster advances
- `frame_start` out 1: one-clock strobe, asserted with the tick that moves to (0,0)
- `uo_out` out 8: packed VGA word {hs, b0, g0, r0, vs, b1, g1, r1}, MSB first; channel bit 1 is the colour MSB

## Operation

- Divider counter `div` runs 0..CLK_DIV-1 while `enable`=1.
  - `pix_tick` = (`div`==CLK_DIV-1) && `enable`.
  - When `enable`=0, `div`, the counters and `uo_out` hold their values.
- Horizontal counter:
  - Increments on each tick.
  - Wraps from H_TOTAL-1 (799) to 0, and that wrap increments the vertical counter.
- Vertical counter wraps from V_TOTAL-1 (524) to 0. That combined wrap raises `frame_start`.
- Horizontal phase FSM: ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - Transitions at `hpos` = 640, 656, 752, and 0 respectively.
  - Vertical phase uses the same structure at `vpos` = 480, 490, 492, and 0.
- Syncs are active-low:
  - hs = 0 iff `hpos` is in [656, 751].
  - vs = 0 iff `vpos` is in [490, 491].
- Output register updates on `pix_tick`:
  - Colour bits take `pix_*` when `active`, otherwise 0. No colour is driven in blanking.
  - hs and vs take the sync value for the current `hpos`/`vpos`.
- Width rules:
  - All counters are 10 bits; totals of 800 and 525 fit.
  - Comparisons use parameter-derived constants only. There is no arithmetic on the pixel data.
- Reset (asynchronous, any time, including mid-line or mid-sync):
  - `div`, `hpos` and `vpos` go to 0.
  - `pix_tick` and `frame_start` go to 0.
  - `uo_out` goes to 8'h88 (syncs inactive, colour black).
  - Phase FSMs go to ACTIVE.

## Timing

- Raster period:
  - One pixel = CLK_DIV clocks.
  - One line = 800 ticks = 1600 clocks.
  - One frame = 525 lines = 840 000 clocks.
- First tick occurs on the CLK_DIV-th rising edge after reset deasserts with `enable`=1.
- Renderer contract:
  - `hpos`, `vpos` and `active` are stable for a full pixel period.
  - `pix_*` must be valid at the edge where `pix_tick`=1. It is sampled there.
- Latency: `uo_out` reflects position (h,v) exactly one pixel period after `hpos`/`vpos` show (h,v). Colour and syncs carry identical latency, so they stay aligned.
- `frame_start` coincides with the tick whose edge loads `hpos`=`vpos`=0.
- `enable` deasserted mid-pixel: `div` freezes and the pixel resumes where it stopped. No tick is lost or duplicated.

## Structure

- Shared constants file holds:
  - the 640x480 timing defaults;
  - derived totals and sync-window bounds;
  - `uo_out` bit positions, which the FPGA top level also uses for unpacking.
- One sub-module is natural: `vga_axis_counter`.
  - Contains a parameterised counter, a 4-state phase FSM and sync decode.
  - Instantiated twice: horizontal, advanced by the tick; vertical, advanced by the horizontal wrap.

## Test plan

- Reset check: assert `reset` mid-frame → `uo_out`=8'h88, `hpos`=`vpos`=0 immediately, with no clock needed; first `pix_tick` 2 clocks after release.
- Line timing: free run → consecutive `hpos` wraps are 1600 clocks apart; hs (`uo_out[7]`) is low for exactly 96 ticks, starting one pixel after `hpos`=656.
- Frame timing: free run → `frame_start` every 840 000 clocks; vs (`uo_out[3]`) is low for exactly 2 lines, starting one pixel after `vpos`=490.
- Colour packing: `pix_r`=2'b10, `pix_g`=2'b01, `pix_b`=2'b11 held constant → active-area `uo_out`=8'hED; blanking outside sync = 8'h88.
- Blanking: colour inputs held at all-ones while `hpos` is in [640, 655] → `uo_out`=8'h88, never nonzero colour bits.
- Enable pause: drop `enable` for 37 clocks mid-line → `hpos`, `vpos`, `uo_out` frozen; after resume the line still totals 800 ticks.

Source files
------------

// File: rtl/tinyvga_gen_pkg.sv
// Shared TinyVGA constants: 640x480@60 timing defaults, derived window
// bounds, and the bit layout of the packed PMOD word (the FPGA top level
// unpacks uo_out using the same positions).
package tinyvga_gen_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP; // 800
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP; // 525
  localparam int DEF_H_SYNC_FIRST = DEF_H_ACTIVE + DEF_H_FP;                         // 656
  localparam int DEF_H_SYNC_LAST  = DEF_H_SYNC_FIRST + DEF_H_SYNC - 1;              // 751
  localparam int DEF_V_SYNC_FIRST = DEF_V_ACTIVE + DEF_V_FP;                         // 490
  localparam int DEF_V_SYNC_LAST  = DEF_V_SYNC_FIRST + DEF_V_SYNC - 1;              // 491

  // uo_out = {hs, b0, g0, r0, vs, b1, g1, r1}
  localparam int UO_HS = 7;
  localparam int UO_B0 = 6;
  localparam int UO_G0 = 5;
  localparam int UO_R0 = 4;
  localparam int UO_VS = 3;
  localparam int UO_B1 = 2;
  localparam int UO_G1 = 1;
  localparam int UO_R1 = 0;

  // Syncs inactive (high), colour black
  localparam logic [7:0] UO_IDLE = 8'h88;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_e;

  function automatic logic [7:0] uo_pack(input logic hs, input logic vs,
                                         input logic [1:0] r, input logic [1:0] g,
                                         input logic [1:0] b);
    logic [7:0] w;
    w        = '0;
    w[UO_HS] = hs;
    w[UO_VS] = vs;
    w[UO_R1] = r[1];
    w[UO_R0] = r[0];
    w[UO_G1] = g[1];
    w[UO_G0] = g[0];
    w[UO_B1] = b[1];
    w[UO_B0] = b[0];
    return w;
  endfunction

endpackage

// File: rtl/tinyvga_gen_axis_counter.sv
// One raster axis: position counter with wrap strobe, plus a 4-phase
// FSM (active/front/sync/back) that tracks where the counter sits so the
// active and sync flags come straight from registered state.
module vga_axis_counter import tinyvga_gen_pkg::*; #(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             adv_i,
  output logic [CNT_W-1:0] pos_o,
  output logic             wrap_o,
  output logic             active_o,
  output logic             sync_n_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_AT  = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] pos_q, pos_d;
  phase_e           phase_q, phase_d;

  assign wrap_o   = adv_i && (pos_q == LAST);
  assign pos_o    = pos_q;
  assign active_o = (phase_q == PH_ACTIVE);
  assign sync_n_o = (phase_q != PH_SYNC);

  // Next position: step on advance, wrapping at the axis total
  always_comb begin
    pos_d = pos_q;
    if (adv_i) pos_d = (pos_q == LAST) ? '0 : pos_q + CNT_W'(1);
  end

  // Phase moves on the same advance that loads its boundary position
  always_comb begin
    phase_d = phase_q;
    if (adv_i) begin
      unique case (phase_q)
        PH_ACTIVE: if (pos_d == FRONT_AT) phase_d = PH_FRONT;
        PH_FRONT:  if (pos_d == SYNC_AT)  phase_d = PH_SYNC;
        PH_SYNC:   if (pos_d == BACK_AT)  phase_d = PH_BACK;
        PH_BACK:   if (pos_d == '0)       phase_d = PH_ACTIVE;
        default:   phase_d = PH_ACTIVE;
      endcase
    end
  end

  // Position and phase registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_q   <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      pos_q   <= pos_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/tinyvga_gen.sv
// TinyVGA source: pixel-rate divider, horizontal/vertical axis counters,
// and the registered PMOD output word. Colour and syncs are registered on
// the same tick so both lag hpos/vpos by exactly one pixel.
module tinyvga_gen import tinyvga_gen_pkg::*; #(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       pix_r,
  input  logic [1:0]       pix_g,
  input  logic [1:0]       pix_b,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             active,
  output logic             pix_tick,
  output logic             frame_start,
  output logic [7:0]       uo_out
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       uo_q, uo_d;
  logic             h_wrap, h_active, h_sync_n;
  logic             v_wrap, v_active, v_sync_n;

  // Reset gating keeps the strobe low while held in reset for any CLK_DIV
  assign pix_tick    = enable && !reset && (div_q == DIV_LAST);
  assign frame_start = h_wrap && v_wrap;
  assign active      = h_active && v_active;
  assign uo_out      = uo_q;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clock    (clock),
    .reset    (reset),
    .adv_i    (pix_tick),
    .pos_o    (hpos),
    .wrap_o   (h_wrap),
    .active_o (h_active),
    .sync_n_o (h_sync_n)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clock    (clock),
    .reset    (reset),
    .adv_i    (h_wrap),
    .pos_o    (vpos),
    .wrap_o   (v_wrap),
    .active_o (v_active),
    .sync_n_o (v_sync_n)
  );

  // Divider counts only while enabled, so a pause resumes mid-pixel
  always_comb begin
    div_d = div_q;
    if (enable) div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  end

  // Output word: sample colour (blanked outside active) and syncs on the tick
  always_comb begin
    uo_d = uo_q;
    if (pix_tick)
      uo_d = uo_pack(h_sync_n, v_sync_n,
                     active ? pix_r : 2'b00,
                     active ? pix_g : 2'b00,
                     active ? pix_b : 2'b00);
  end

  // Divider and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      uo_q  <= UO_IDLE;
    end else begin
      div_q <= div_d;
      uo_q  <= uo_d;
    end
  end

endmodule

// File: tb/tb_tinyvga_gen.sv
// Bench for tinyvga_gen: a raster model pushes the expected state for every
// pixel tick; a monitor pops and compares whenever the DUT strobes pix_tick.
// Directed sequences cover reset, line timing, packing, blanking and pause;
// a reduced-timing instance covers frame wrap and vertical sync.
module tb_tinyvga_gen;

  typedef struct {
    int         h;
    int         v;
    logic [7:0] uo;
    logic       fs;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] pix_r = 2'b00, pix_g = 2'b00, pix_b = 2'b00;
  logic [9:0] hpos, vpos;
  logic       active, pix_tick, frame_start;
  logic [7:0] uo_out;

  logic       s_en = 1'b1;
  logic [1:0] s_pix = 2'b11;
  logic [9:0] s_hpos, s_vpos;
  logic       s_active, s_tick, s_fs;
  logic [7:0] s_uo;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  tinyvga_gen dut (
    .clock(clock), .reset(reset), .enable(enable),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .hpos(hpos), .vpos(vpos), .active(active), .pix_tick(pix_tick),
    .frame_start(frame_start), .uo_out(uo_out)
  );

  // 16x8 raster: sync windows h [10,13], v [5,6]; frame = 256 clocks
  tinyvga_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clock(clock), .reset(reset), .enable(s_en),
    .pix_r(s_pix), .pix_g(s_pix), .pix_b(s_pix),
    .hpos(s_hpos), .vpos(s_vpos), .active(s_active), .pix_tick(s_tick),
    .frame_start(s_fs), .uo_out(s_uo)
  );

  initial forever #5 clock = ~clock;
  initial forever begin @(posedge clock); cyc++; end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected PMOD word for position (h,v) of the 640x480 raster
  function automatic logic [7:0] exp_word(input int h, input int v,
                                          input logic [1:0] r, input logic [1:0] g,
                                          input logic [1:0] b);
    logic       act, hs, vs;
    logic [1:0] rr, gg, bb;
    act = (h < 640) && (v < 480);
    hs  = !((h >= 656) && (h <= 751));
    vs  = !((v >= 490) && (v <= 491));
    rr  = act ? r : 2'b00;
    gg  = act ? g : 2'b00;
    bb  = act ? b : 2'b00;
    return {hs, bb[0], gg[0], rr[0], vs, bb[1], gg[1], rr[1]};
  endfunction

  // Raster model: inputs change only just after posedge, so the values seen
  // at negedge are the ones the coming posedge samples.
  int         mh = 0, mv = 0, mdiv = 0;
  logic [7:0] muo = 8'h88;
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (!reset && enable && mdiv == 1) begin
      e.h = mh; e.v = mv; e.uo = muo; e.fs = (mh == 799) && (mv == 524);
      sb.push_back(e);
    end
    if (reset) begin
      mh = 0; mv = 0; mdiv = 0; muo = 8'h88;
    end else if (enable) begin
      if (mdiv == 1) begin
        muo  = exp_word(mh, mv, pix_r, pix_g, pix_b);
        mdiv = 0;
        if (mh == 799) begin
          mh = 0;
          mv = (mv == 524) ? 0 : mv + 1;
        end else mh++;
      end else mdiv++;
    end
  end

  // Monitor: each DUT tick consumes one expected entry
  initial forever begin
    exp_t e;
    @(negedge clock);
    #1;
    if (pix_tick) begin
      if (sb.size() == 0) chk("spurious_tick", pix_tick, 0);
      else begin
        e = sb.pop_front();
        chk("tick_hpos", hpos, e.h);
        chk("tick_vpos", vpos, e.v);
        chk("tick_uo_out", uo_out, e.uo);
        chk("tick_frame_start", frame_start, e.fs);
        chk("tick_active", active, (e.h < 640) && (e.v < 480));
      end
    end else if (sb.size() != 0) begin
      chk("missing_tick", pix_tick, 1);
      sb.delete();
    end
  end

  task automatic align();
    @(posedge clock);
    #2;
  endtask

  task automatic next_tick(output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 8) begin
      @(negedge clock);
      #2;
      n++;
      if (pix_tick) ok = 1'b1;
    end
    if (!ok) chk("tick_timeout", 0, 1);
  endtask

  task automatic wait_h(input int h);
    bit ok;
    int n;
    n = 0;
    do begin
      next_tick(ok);
      n++;
    end while (ok && hpos != h && n < 2000);
    if (!(ok && hpos == h)) chk("wait_hpos_timeout", hpos, h);
  endtask

  task automatic first_tick_latency();
    int n;
    n = 0;
    do begin
      @(posedge clock);
      n++;
      #1;
    end while (hpos != 1 && n < 10);
    chk("first_tick_clocks", n, 2);
  endtask

  initial begin
    bit ok;
    int c0, hsl, first, cnt, fh, fv;

    // Reset state
    repeat (3) @(posedge clock);
    #2;
    chk("rst_hpos", hpos, 0);
    chk("rst_vpos", vpos, 0);
    chk("rst_uo_out", uo_out, 8'h88);
    chk("rst_pix_tick", pix_tick, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_active", active, 1);

    // Release with fixed colour r=10 g=01 b=11
    reset = 1'b0; enable = 1'b1;
    pix_r = 2'b10; pix_g = 2'b01; pix_b = 2'b11;
    first_tick_latency();
    wait_h(10);
    chk("colour_packing", uo_out, 8'hED);

    // One full line: clock count, hs width and hs alignment
    wait_h(0);
    c0 = cyc; hsl = 0; first = -1;
    do begin
      next_tick(ok);
      if (!uo_out[7]) begin
        hsl++;
        if (first < 0) first = hpos;
      end
    end while (ok && hpos != 0);
    chk("line_clocks", cyc - c0, 1600);
    chk("hs_low_ticks", hsl, 96);
    chk("hs_first_hpos", first, 657);

    // All-ones colour: front porch stays blank, sync shows hs only
    align();
    pix_r = 2'b11; pix_g = 2'b11; pix_b = 2'b11;
    wait_h(641);
    for (int i = 0; i < 16; i++) begin
      chk("blank_front_porch", uo_out, 8'h88);
      next_tick(ok);
    end
    chk("blank_sync", uo_out, 8'h08);
    wait_h(5);
    chk("active_all_ones", uo_out, 8'hFF);

    // Pause mid-pixel for 37 clocks; line must still be 800 ticks
    wait_h(0);
    cnt = 0;
    do begin
      next_tick(ok);
      cnt++;
      if (cnt == 300) begin
        align();
        align();
        enable = 1'b0;
        for (int i = 0; i < 37; i++) begin
          @(negedge clock);
          #2;
          chk("pause_hpos", hpos, 301);
          chk("pause_vpos", vpos, mv);
          chk("pause_uo_out", uo_out, 8'hFF);
          chk("pause_tick", pix_tick, 0);
        end
        align();
        enable = 1'b1;
      end
    end while (ok && hpos != 0 && cnt < 2000);
    chk("line_ticks_with_pause", cnt, 800);

    // Asynchronous reset in the middle of hsync
    wait_h(700);
    align();
    reset = 1'b1;
    #1;
    chk("async_rst_hpos", hpos, 0);
    chk("async_rst_vpos", vpos, 0);
    chk("async_rst_uo_out", uo_out, 8'h88);
    chk("async_rst_pix_tick", pix_tick, 0);
    align();
    align();
    reset = 1'b0;
    first_tick_latency();

    // Reduced raster: frame period, frame_start position, vsync window
    cnt = 0;
    do begin
      @(negedge clock);
      #2;
      cnt++;
    end while (!s_fs && cnt < 600);
    chk("s_fs_seen", s_fs, 1);
    chk("s_fs_hpos", s_hpos, 15);
    chk("s_fs_vpos", s_vpos, 7);
    c0 = cyc; hsl = 0; fh = -1; fv = -1; cnt = 0;
    do begin
      @(negedge clock);
      #2;
      cnt++;
      if (s_tick && !s_uo[3]) begin
        hsl++;
        if (fh < 0) begin fh = s_hpos; fv = s_vpos; end
      end
    end while (!s_fs && cnt < 600);
    chk("s_frame_clocks", cyc - c0, 256);
    chk("s_vs_low_ticks", hsl, 32);
    chk("s_vs_first_hpos", fh, 1);
    chk("s_vs_first_vpos", fv, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
